// File: rtl/xa_bf_dir_seq.sv
// Beam-sweep sequencer: one calculator start per beam, a single outstanding
// calculation with timeout, and a valid/ready result handoff downstream.
module xa_bf_dir_seq #(
    parameter int P_TIMEOUT  = 63,
    parameter int P_BEAM_MAX = 512
) (
    input  logic        i_arst,
    input  logic        i_clk156m,
    input  logic        i_frm_start,
    input  logic [9:0]  i_beam_num,
    input  logic [31:0] i_beam_phi,
    input  logic [31:0] i_snd_spd,
    output logic        o_calc_start,
    output logic [9:0]  o_calc_beam_idx,
    output logic [31:0] o_calc_beam_phi,
    output logic [31:0] o_calc_snd_spd,
    input  logic        i_calc_done,
    input  logic [31:0] i_calc_x,
    input  logic [31:0] i_calc_y,
    input  logic [31:0] i_calc_z,
    output logic        o_dir_valid,
    input  logic        i_dir_ready,
    output logic [9:0]  o_dir_beam_idx,
    output logic [31:0] o_dir_x,
    output logic [31:0] o_dir_y,
    output logic [31:0] o_dir_z,
    output logic        o_busy,
    output logic        o_frm_done,
    output logic [1:0]  o_err
);

    localparam int CW = $clog2(P_TIMEOUT + 1);
    localparam logic [CW-1:0] C_TO_LAST = CW'(P_TIMEOUT - 1);
    localparam logic [9:0] C_MAX = 10'(P_BEAM_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0] r_cnt;
    logic [9:0]    r_num;
    logic [9:0]    r_idx;
    logic [31:0]   r_phi;
    logic [31:0]   r_snd;
    logic [9:0]    r_dir_idx;
    logic [31:0]   r_dir_x;
    logic [31:0]   r_dir_y;
    logic [31:0]   r_dir_z;
    logic [1:0]    r_err;

    logic [9:0] w_num;
    logic       w_timeout;
    logic       w_last;
    logic       w_accept;

    assign w_num     = (i_beam_num > C_MAX) ? C_MAX : i_beam_num;
    assign w_last    = (r_idx == r_num - 10'd1);
    assign w_accept  = (r_state == S_OUT) && i_dir_ready;
    // a done arriving in the timeout cycle still counts as success
    assign w_timeout = (r_state == S_WAIT) && !i_calc_done &&
                       (r_cnt == C_TO_LAST);

    always_ff @(posedge i_clk156m or posedge i_arst) begin
        if (i_arst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_frm_start) begin
                    w_next = (w_num == 10'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (i_calc_done) begin
                    w_next = S_OUT;
                end else if (w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_OUT: begin
                if (i_dir_ready) begin
                    w_next = w_last ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_calc_start = (r_state == S_ISSUE);
        o_dir_valid  = (r_state == S_OUT);
        o_busy       = (r_state != S_IDLE);
        o_frm_done   = (r_state == S_DONE);
    end

    always_ff @(posedge i_clk156m or posedge i_arst) begin
        if (i_arst) begin
            r_cnt     <= '0;
            r_num     <= '0;
            r_idx     <= '0;
            r_phi     <= '0;
            r_snd     <= '0;
            r_dir_idx <= '0;
            r_dir_x   <= '0;
            r_dir_y   <= '0;
            r_dir_z   <= '0;
            r_err     <= '0;
        end else begin
            if (i_frm_start) begin
                if (r_state == S_IDLE) begin
                    r_phi <= i_beam_phi;
                    r_snd <= i_snd_spd;
                    r_num <= w_num;
                    r_err <= '0;
                    if (w_num != 10'd0) begin
                        r_idx <= '0;
                    end
                end else begin
                    r_err[1] <= 1'b1;
                end
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end
            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
                if (i_calc_done) begin
                    r_dir_idx <= r_idx;
                    r_dir_x   <= i_calc_x;
                    r_dir_y   <= i_calc_y;
                    r_dir_z   <= i_calc_z;
                end
            end
            if (w_timeout) begin
                r_err[0] <= 1'b1;
            end
            if (w_accept && !w_last) begin
                r_idx <= r_idx + 10'd1;
            end
        end
    end

    assign o_calc_beam_idx = r_idx;
    assign o_calc_beam_phi = r_phi;
    assign o_calc_snd_spd  = r_snd;
    assign o_dir_beam_idx  = r_dir_idx;
    assign o_dir_x         = r_dir_x;
    assign o_dir_y         = r_dir_y;
    assign o_dir_z         = r_dir_z;
    assign o_err           = r_err;

endmodule

// File: tb/tb_xa_bf_dir_seq.sv
// Scoreboard bench for xa_bf_dir_seq with a fixed-latency calculator model.
// Stimulus pushes expected starts, beats and frame ends; monitors pop them.
module tb_xa_bf_dir_seq;

    logic        i_arst;
    logic        i_clk156m = 1'b0;
    logic        i_frm_start;
    logic [9:0]  i_beam_num;
    logic [31:0] i_beam_phi;
    logic [31:0] i_snd_spd;
    logic        o_calc_start;
    logic [9:0]  o_calc_beam_idx;
    logic [31:0] o_calc_beam_phi;
    logic [31:0] o_calc_snd_spd;
    logic        i_calc_done;
    logic [31:0] i_calc_x;
    logic [31:0] i_calc_y;
    logic [31:0] i_calc_z;
    logic        o_dir_valid;
    logic        i_dir_ready;
    logic [9:0]  o_dir_beam_idx;
    logic [31:0] o_dir_x;
    logic [31:0] o_dir_y;
    logic [31:0] o_dir_z;
    logic        o_busy;
    logic        o_frm_done;
    logic [1:0]  o_err;

    xa_bf_dir_seq dut (
        .i_arst          (i_arst),
        .i_clk156m       (i_clk156m),
        .i_frm_start     (i_frm_start),
        .i_beam_num      (i_beam_num),
        .i_beam_phi      (i_beam_phi),
        .i_snd_spd       (i_snd_spd),
        .o_calc_start    (o_calc_start),
        .o_calc_beam_idx (o_calc_beam_idx),
        .o_calc_beam_phi (o_calc_beam_phi),
        .o_calc_snd_spd  (o_calc_snd_spd),
        .i_calc_done     (i_calc_done),
        .i_calc_x        (i_calc_x),
        .i_calc_y        (i_calc_y),
        .i_calc_z        (i_calc_z),
        .o_dir_valid     (o_dir_valid),
        .i_dir_ready     (i_dir_ready),
        .o_dir_beam_idx  (o_dir_beam_idx),
        .o_dir_x         (o_dir_x),
        .o_dir_y         (o_dir_y),
        .o_dir_z         (o_dir_z),
        .o_busy          (o_busy),
        .o_frm_done      (o_frm_done),
        .o_err           (o_err)
    );

    always #3 i_clk156m = ~i_clk156m;

    typedef struct {
        int          cyc;
        logic [73:0] pl;
    } st_e;

    st_e          st_q[$];
    logic [105:0] beat_q[$];
    int           done_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int frm_cnt  = 0;
    int busy_cyc = 0;
    int done_at  = -1;
    int last_beat_idx = -1;
    bit calc_en  = 1'b1;
    int start_cyc[1024];
    logic [9:0] model_idx = '0;

    localparam logic [31:0] PHI45 = 32'h42340000;
    localparam logic [31:0] C1500 = 32'h44BB8000;

    function automatic logic [31:0] fx(input int i);
        return 32'h3F800000 | 32'(i);
    endfunction
    function automatic logic [31:0] fy(input int i);
        return 32'hC0000000 | (32'(i) << 4);
    endfunction
    function automatic logic [31:0] fz(input int i);
        return 32'h40400000 ^ (32'(i) << 22);
    endfunction

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    always @(posedge i_clk156m) cyc <= cyc + 1;

    // calculator model: done exactly 52 cycles after the start cycle
    always @(negedge i_clk156m) begin
        if (o_calc_start) begin
            done_at   = cyc + 52;
            model_idx = o_calc_beam_idx;
        end
    end
    always @(posedge i_clk156m) begin
        #1;
        i_calc_done = calc_en && (cyc == done_at);
        i_calc_x = fx(int'(model_idx));
        i_calc_y = fy(int'(model_idx));
        i_calc_z = fz(int'(model_idx));
    end

    always @(negedge i_clk156m) begin
        st_e se;
        logic [105:0] be;
        int dc;
        if (o_busy) busy_cyc++;
        if (o_calc_start) begin
            start_cyc[o_calc_beam_idx] = cyc;
            if (st_q.size() == 0) begin
                check("unexpected_calc_start", 1, 0);
            end else begin
                se = st_q.pop_front();
                check("calc_start_payload",
                      {o_calc_beam_idx, o_calc_beam_phi, o_calc_snd_spd}, se.pl);
                if (se.cyc >= 0) check("calc_start_cycle", cyc, se.cyc);
            end
        end
        if (o_dir_valid && i_dir_ready) begin
            last_beat_idx = int'(o_dir_beam_idx);
            if (beat_q.size() == 0) begin
                check("unexpected_dir_beat", 1, 0);
            end else begin
                be = beat_q.pop_front();
                check("dir_beat", {o_dir_beam_idx, o_dir_x, o_dir_y, o_dir_z}, be);
            end
        end
        if (o_frm_done) begin
            frm_cnt++;
            if (done_q.size() == 0) begin
                check("unexpected_frm_done", 1, 0);
            end else begin
                dc = done_q.pop_front();
                if (dc >= 0) check("frm_done_cycle", cyc, dc);
            end
        end
    end

    task automatic launch(input int num, input logic [31:0] phi,
                          input logic [31:0] snd, output int t);
        @(posedge i_clk156m);
        #1;
        i_frm_start = 1'b1;
        i_beam_num  = 10'(num);
        i_beam_phi  = phi;
        i_snd_spd   = snd;
        t = cyc;
        @(posedge i_clk156m);
        #1;
        i_frm_start = 1'b0;
    endtask

    task automatic push_frame(input int t, input int n, input logic [31:0] phi,
                              input logic [31:0] snd, input bit timed,
                              input int done_cyc);
        for (int i = 0; i < n; i++) begin
            st_q.push_back('{timed ? t + 1 + 54 * i : -1, {10'(i), phi, snd}});
            beat_q.push_back({10'(i), fx(i), fy(i), fz(i)});
        end
        done_q.push_back(done_cyc);
    endtask

    task automatic wait_frame(input int budget);
        int c0 = frm_cnt;
        for (int k = 0; k < budget && frm_cnt == c0; k++) @(posedge i_clk156m);
        check("frame_end_seen", frm_cnt != c0, 1);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_calc"},
              {o_calc_start, o_calc_beam_idx, o_calc_beam_phi, o_calc_snd_spd}, 0);
        check({tag, "_dir"},
              {o_dir_valid, o_dir_beam_idx, o_dir_x, o_dir_y, o_dir_z}, 0);
        check({tag, "_stat"}, {o_busy, o_frm_done, o_err}, 0);
    endtask

    initial begin
        int t;
        int v;
        int stable;
        int f0;
        logic [105:0] snap;
        i_arst = 1'b1;
        i_frm_start = 1'b0;
        i_beam_num = '0;
        i_beam_phi = '0;
        i_snd_spd = '0;
        i_dir_ready = 1'b1;
        repeat (3) @(posedge i_clk156m);
        @(negedge i_clk156m);
        chk_zero("reset");
        @(posedge i_clk156m);
        #1 i_arst = 1'b0;
        repeat (2) @(posedge i_clk156m);

        // three beams, ready held high
        launch(3, PHI45, C1500, t);
        push_frame(t, 3, PHI45, C1500, 1'b1, t + 163);
        wait_frame(400);

        // stall beam 0 for ten cycles
        i_dir_ready = 1'b0;
        launch(2, 32'h3F800000, C1500, t);
        push_frame(t, 2, 32'h3F800000, C1500, 1'b0, t + 119);
        for (int k = 0; k < 200 && !o_dir_valid; k++) @(negedge i_clk156m);
        check("stall_valid_seen", o_dir_valid, 1);
        snap = {o_dir_beam_idx, o_dir_x, o_dir_y, o_dir_z};
        v = cyc;
        stable = 1;
        for (int k = 0; k < 9; k++) begin
            @(negedge i_clk156m);
            if (o_dir_valid && {o_dir_beam_idx, o_dir_x, o_dir_y, o_dir_z} == snap)
                stable++;
        end
        @(posedge i_clk156m);
        #1 i_dir_ready = 1'b1;
        @(negedge i_clk156m);
        if (o_dir_valid && {o_dir_beam_idx, o_dir_x, o_dir_y, o_dir_z} == snap)
            stable++;
        check("stall_stable_cycles", stable, 11);
        wait_frame(200);
        check("start_after_accept", start_cyc[1], v + 11);

        // empty frame
        repeat (2) @(posedge i_clk156m);
        busy_cyc = 0;
        launch(0, PHI45, C1500, t);
        push_frame(t, 0, PHI45, C1500, 1'b1, t + 1);
        wait_frame(10);
        repeat (3) @(posedge i_clk156m);
        check("empty_busy_cycles", busy_cyc, 1);

        // calculator never answers
        calc_en = 1'b0;
        launch(3, PHI45, C1500, t);
        st_q.push_back('{t + 1, {10'd0, PHI45, C1500}});
        done_q.push_back(t + 65);
        wait_frame(200);
        check("timeout_err", o_err, 2'b01);
        calc_en = 1'b1;

        launch(1, 32'h40000000, C1500, t);
        push_frame(t, 1, 32'h40000000, C1500, 1'b1, t + 55);
        @(negedge i_clk156m);
        check("err_cleared", o_err, 2'b00);
        wait_frame(200);

        // stray frame start mid-frame
        launch(2, PHI45, 32'h44C80000, t);
        push_frame(t, 2, PHI45, 32'h44C80000, 1'b1, t + 109);
        repeat (30) @(posedge i_clk156m);
        #1 i_frm_start = 1'b1;
        @(posedge i_clk156m);
        #1 i_frm_start = 1'b0;
        wait_frame(300);
        check("busy_start_err", o_err, 2'b10);

        // beam count clamp
        launch(1000, PHI45, C1500, t);
        push_frame(t, 512, PHI45, C1500, 1'b1, t + 1 + 54 * 512);
        wait_frame(54 * 512 + 100);
        check("clamp_last_idx", last_beat_idx, 511);

        // reset while waiting on beam 1
        launch(3, PHI45, C1500, t);
        push_frame(t, 3, PHI45, C1500, 1'b1, t + 163);
        while (cyc < t + 70) @(posedge i_clk156m);
        #1;
        i_arst = 1'b1;
        done_at = -1;
        st_q.delete();
        beat_q.delete();
        done_q.delete();
        f0 = frm_cnt;
        #1;
        chk_zero("midreset");
        repeat (3) @(posedge i_clk156m);
        #1 i_arst = 1'b0;
        repeat (5) @(posedge i_clk156m);
        check("midreset_no_done", frm_cnt, f0);
        launch(2, PHI45, C1500, t);
        push_frame(t, 2, PHI45, C1500, 1'b1, t + 109);
        wait_frame(300);

        repeat (5) @(posedge i_clk156m);
        check("starts_drained", st_q.size(), 0);
        check("beats_drained", beat_q.size(), 0);
        check("dones_drained", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
